// File: rtl/wildcard_match_scheduler.sv
// Wildcard pattern table scanned by one shared comparator, one entry per cycle; hit at index k
// responds k+1 cycles after acceptance, a miss after ENTRIES cycles. One lookup in flight; resp held until resp_ready.
module wildcard_match_scheduler #(
    parameter int DATA_W  = 8,
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [DATA_W-1:0] cfg_value,
    input  logic [DATA_W-1:0] cfg_care,
    input  logic              cfg_en,
    input  logic              cfg_clear,
    output logic              cfg_ready,
    input  logic              req_valid,
    input  logic [DATA_W-1:0] req_data,
    output logic              req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_hit,
    output logic [IDX_W-1:0]  resp_idx,
    output logic [CNT_W-1:0]  stat_lookups,
    output logic [CNT_W-1:0]  stat_hits
);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] value;
        logic [DATA_W-1:0] care;
    } entry_t;

    state_t              state, state_nxt;
    entry_t              pat_tab [ENTRIES];
    logic [ENTRIES-1:0]  valid;
    logic [DATA_W-1:0]   key;
    logic [IDX_W-1:0]    ptr;
    logic                entry_hit;
    logic                scan_last;

    assign cfg_ready = (state == IDLE);
    assign req_ready = (state == IDLE);

    assign entry_hit = valid[ptr] &&
                       (((key ^ pat_tab[ptr].value) & pat_tab[ptr].care) == '0);
    assign scan_last = (ptr == IDX_W'(ENTRIES - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = SCAN;
            SCAN:    if (entry_hit || scan_last) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pattern storage carries no reset; only the valid bits define table contents.
    always_ff @(posedge clk) begin
        if (!rst && cfg_ready && cfg_we) begin
            pat_tab[cfg_idx] <= '{value: cfg_value, care: cfg_care};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            valid        <= '0;
            ptr          <= '0;
            key          <= '0;
            resp_valid   <= 1'b0;
            resp_hit     <= 1'b0;
            resp_idx     <= '0;
            stat_lookups <= '0;
            stat_hits    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    // Clear first, then the write, so the written entry survives a combined op.
                    if (cfg_clear) valid <= '0;
                    if (cfg_we) valid[cfg_idx] <= cfg_en;
                    if (req_valid) begin
                        key <= req_data;
                        ptr <= '0;
                    end
                end
                SCAN: begin
                    if (entry_hit) begin
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b1;
                        resp_idx   <= ptr;
                    end else if (scan_last) begin
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b0;
                        resp_idx   <= '0;
                    end else begin
                        ptr <= ptr + IDX_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        if (stat_lookups != '1) stat_lookups <= stat_lookups + CNT_W'(1);
                        if (resp_hit && stat_hits != '1) stat_hits <= stat_hits + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wildcard_match_scheduler.sv
// Directed bench: transaction-level table model checked every cycle, plus literal expectations per lookup.
module tb_wildcard_match_scheduler;

    localparam int DATA_W  = 8;
    localparam int ENTRIES = 8;
    localparam int IDX_W   = 3;
    localparam int CNT_W   = 3;   // small so saturation is reachable

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [IDX_W-1:0]  cfg_idx = '0;
    logic [DATA_W-1:0] cfg_value = '0;
    logic [DATA_W-1:0] cfg_care = '0;
    logic              cfg_en = 1'b0;
    logic              cfg_clear = 1'b0;
    logic              cfg_ready;
    logic              req_valid = 1'b0;
    logic [DATA_W-1:0] req_data = '0;
    logic              req_ready;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic              resp_hit;
    logic [IDX_W-1:0]  resp_idx;
    logic [CNT_W-1:0]  stat_lookups;
    logic [CNT_W-1:0]  stat_hits;

    int checks = 0;
    int errors = 0;

    wildcard_match_scheduler #(
        .DATA_W(DATA_W), .ENTRIES(ENTRIES), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_value(cfg_value), .cfg_care(cfg_care),
        .cfg_en(cfg_en), .cfg_clear(cfg_clear), .cfg_ready(cfg_ready),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .resp_idx(resp_idx), .stat_lookups(stat_lookups), .stat_hits(stat_hits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DATA_W-1:0] m_val  [ENTRIES];
    logic [DATA_W-1:0] m_care [ENTRIES];
    bit                m_en   [ENTRIES];
    bit  m_busy = 0, m_rv = 0, m_hit = 0;
    int  m_idx = 0, m_wait = 0, m_lookups = 0, m_hits = 0;
    localparam int SAT = (1 << CNT_W) - 1;

    function automatic void model_lookup(input logic [DATA_W-1:0] k, output bit hit, output int idx);
        hit = 0;
        idx = 0;
        for (int i = 0; i < ENTRIES; i++)
            if (!hit && m_en[i] && (((k ^ m_val[i]) & m_care[i]) == 0)) begin
                hit = 1;
                idx = i;
            end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_rv = 0; m_lookups = 0; m_hits = 0;
            for (int i = 0; i < ENTRIES; i++) m_en[i] = 0;
        end else if (!m_busy) begin
            if (cfg_clear) for (int i = 0; i < ENTRIES; i++) m_en[i] = 0;
            if (cfg_we) begin
                m_val[cfg_idx] = cfg_value;
                m_care[cfg_idx] = cfg_care;
                m_en[cfg_idx] = cfg_en;
            end
            if (req_valid) begin
                model_lookup(req_data, m_hit, m_idx);
                m_wait = m_hit ? m_idx + 1 : ENTRIES;
                m_busy = 1;
            end
        end else if (!m_rv) begin
            m_wait--;
            if (m_wait == 0) m_rv = 1;
        end else if (resp_ready) begin
            if (m_lookups < SAT) m_lookups++;
            if (m_hit && m_hits < SAT) m_hits++;
            m_busy = 0;
            m_rv = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_req_ready", req_ready, !m_busy);
            chk("cyc_cfg_ready", cfg_ready, !m_busy);
            chk("cyc_resp_valid", resp_valid, m_rv);
            chk("cyc_stat_lookups", stat_lookups, m_lookups);
            chk("cyc_stat_hits", stat_hits, m_hits);
            if (m_rv) begin
                chk("cyc_resp_hit", resp_hit, m_hit);
                chk("cyc_resp_idx", resp_idx, m_idx);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_op(input int idx, input logic [7:0] v, input logic [7:0] c,
                          input bit en, input bit we, input bit clr);
        cfg_idx = IDX_W'(idx); cfg_value = v; cfg_care = c; cfg_en = en;
        cfg_we = we; cfg_clear = clr;
        tick();
        cfg_we = 0; cfg_clear = 0;
    endtask

    task automatic lookup(input logic [7:0] k, input bit e_hit, input int e_idx,
                          input int e_lat, input int hold, input bit cfg_in_hold);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin tick(); n++; end
        if (!req_ready) chk("req_ready_timeout", 0, 1);
        req_valid = 1; req_data = k;
        tick();
        req_valid = 0; req_data = ~k;
        n = 0;
        while (!resp_valid && n < 40) begin tick(); n++; end
        if (!resp_valid) chk("resp_valid_timeout", 0, 1);
        chk("lat", n, e_lat);
        chk("hit", resp_hit, e_hit);
        chk("idx", resp_idx, e_idx);
        for (int h = 0; h < hold; h++) begin
            chk("hold_req_ready", req_ready, 0);
            chk("hold_cfg_ready", cfg_ready, 0);
            chk("hold_idx", resp_idx, e_idx);
            if (cfg_in_hold && h == 1) begin
                cfg_idx = 1; cfg_value = 8'hFF; cfg_care = 8'hFF; cfg_en = 1; cfg_we = 1;
            end
            tick();
            cfg_we = 0;
        end
        resp_ready = 1;
        tick();
        resp_ready = 0;
    endtask

    initial begin
        tick(); tick();
        rst = 0;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_hit", resp_hit, 0);
        chk("rst_resp_idx", resp_idx, 0);
        chk("rst_stat_lookups", stat_lookups, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_cfg_ready", cfg_ready, 1);

        cfg_op(0, 8'hA0, 8'hF0, 1, 1, 0);
        lookup(8'hA5, 1, 0, 1, 0, 0);
        chk("s1_lookups", stat_lookups, 1);
        chk("s1_hits", stat_hits, 1);
        lookup(8'hB0, 0, 0, 8, 0, 0);
        chk("s2_lookups", stat_lookups, 2);
        chk("s2_hits", stat_hits, 1);

        cfg_op(2, 8'h50, 8'hF0, 1, 1, 0);
        cfg_op(5, 8'h00, 8'h00, 1, 1, 0);
        lookup(8'h53, 1, 2, 3, 0, 0);
        lookup(8'hFF, 1, 5, 6, 0, 0);

        lookup(8'hFF, 1, 5, 6, 5, 1);
        lookup(8'hFF, 1, 5, 6, 0, 0);

        cfg_op(3, 8'h11, 8'hFF, 1, 1, 1);
        lookup(8'h11, 1, 3, 4, 0, 0);
        lookup(8'hA0, 0, 0, 8, 0, 0);
        chk("sat_lookups", stat_lookups, 7);
        chk("sat_hits", stat_hits, 6);

        req_valid = 1; req_data = 8'h11;
        tick();
        req_valid = 0;
        tick(); tick();
        rst = 1;
        tick();
        rst = 0;
        chk("abort_resp_valid", resp_valid, 0);
        chk("abort_lookups", stat_lookups, 0);
        chk("abort_hits", stat_hits, 0);
        chk("abort_req_ready", req_ready, 1);
        lookup(8'h11, 0, 0, 8, 0, 0);
        chk("post_lookups", stat_lookups, 1);
        chk("post_hits", stat_hits, 0);

        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
